// File: rtl/ram_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ram_arb_pkg : shared types for the single-port RAM arbiter          |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
package ram_arb_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef logic req_id_t;

  function automatic req_id_t other_req(input req_id_t id);
    return ~id;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_rr_arb2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ram_rr_arb2 : two-input round-robin arbiter with pointer register   |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module ram_rr_arb2
  import ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  req_id_t r_ptr;

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = r_ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // The pointer always moves away from whoever just won.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= 1'b0;
    end else if (|grant) begin
      r_ptr <= other_req(req_id_t'(grant[1]));
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ram_port_arbiter : init sweep, then two-requester RAM port sharing  |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef DATA_DEPTH
`define DATA_DEPTH 16
`endif
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int                    DATA_WIDTH = `DATA_WIDTH,
  parameter int                    DATA_DEPTH = `DATA_DEPTH,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  localparam int                   ADDR_WIDTH = $clog2(DATA_DEPTH)
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_ready,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  input  logic                  req1_valid,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  init_done
);

  localparam logic [ADDR_WIDTH-1:0] C_LAST_ADDR = ADDR_WIDTH'(DATA_DEPTH - 1);

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_init_addr, w_init_addr_nxt;
  logic [ADDR_WIDTH-1:0] r_addr_hold;
  logic [DATA_WIDTH-1:0] r_din_hold;
  logic [1:0]            r_rsp_pend, w_rsp_pend_nxt;
  logic [1:0]            w_arb_valid;
  logic [1:0]            w_grant;
  logic                  w_run;

  // Gating with rst keeps every output quiet during the reset cycle itself.
  assign w_run       = (r_state == ST_RUN) && !rst;
  assign w_arb_valid = {req1_valid, req0_valid} & {2{w_run}};

  ram_rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .valid (w_arb_valid),
    .grant (w_grant)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_INIT;
      r_init_addr <= '0;
      r_addr_hold <= '0;
      r_din_hold  <= '0;
      r_rsp_pend  <= 2'b00;
    end else begin
      r_state     <= w_state_nxt;
      r_init_addr <= w_init_addr_nxt;
      r_addr_hold <= ram_addr;
      r_din_hold  <= ram_din;
      r_rsp_pend  <= w_rsp_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_init_addr_nxt = r_init_addr;
    w_rsp_pend_nxt  = 2'b00;
    ram_we          = 1'b0;
    ram_addr        = r_addr_hold;
    ram_din         = r_din_hold;
    init_done       = 1'b0;
    req0_ready      = w_grant[0];
    req1_ready      = w_grant[1];
    if (rst) begin
      ram_addr = '0;
      ram_din  = '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          ram_we          = 1'b1;
          ram_addr        = r_init_addr;
          ram_din         = INIT_VALUE;
          w_init_addr_nxt = r_init_addr + ADDR_WIDTH'(1);
          if (r_init_addr == C_LAST_ADDR) begin
            w_state_nxt     = ST_RUN;
            w_init_addr_nxt = '0;
          end
        end
        ST_RUN: begin
          init_done = 1'b1;
          if (w_grant[0]) begin
            ram_we            = req0_we;
            ram_addr          = req0_addr;
            ram_din           = req0_wdata;
            w_rsp_pend_nxt[0] = !req0_we;
          end else if (w_grant[1]) begin
            ram_we            = req1_we;
            ram_addr          = req1_addr;
            ram_din           = req1_wdata;
            w_rsp_pend_nxt[1] = !req1_we;
          end
        end
        default: w_state_nxt = ST_INIT;
      endcase
    end
  end

  assign rsp0_valid = r_rsp_pend[0] && !rst;
  assign rsp1_valid = r_rsp_pend[1] && !rst;
  assign rsp0_rdata = rsp0_valid ? ram_dout : '0;
  assign rsp1_rdata = rsp1_valid ? ram_dout : '0;

endmodule
`default_nettype wire
